// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pin bundle between a fetch-unit initiator and the flash responder
interface spi_flash_responder_if;
  logic spi_cs;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  modport master (output spi_cs, spi_sclk, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave (input spi_cs, spi_sclk, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI-flash read responder (0x03; 0x0B with SPI_FLASH_RESPONDER_FAST_READ_EN)
module spi_flash_responder #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_responder_if.slave  spi,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [7:0]            load_data,
  output logic                  busy,
  output logic                  cmd_err
);
  // only the trailing bits of the 24-bit address (and the 8-bit opcode) are ever needed
  localparam int SW = AW > 8 ? AW : 8;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  logic fast;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [SYNC_STAGES-1:0] cs_q, sclk_q, mosi_q;
  logic cs_d, sclk_d, cs_s, sclk_s, mosi_s, rise, fall, cs_fall, cmd_err_n;
  logic [SW-2:0] shift_in;
  logic [SW-1:0] shift_nxt;
  logic [4:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [AW-1:0] addr_ptr;
  logic [7:0] shift_out;
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign shift_nxt = {shift_in, mosi_s};
  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cmd_err_n = 1'b0;
    if (cs_s) state_n = IDLE;
    else if (cs_fall) state_n = CMD;
    else if (rise)
      case (state)
        CMD: if (bit_cnt == 5'd7) begin
          if (shift_nxt[7:0] == 8'h03) state_n = ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          else if (shift_nxt[7:0] == 8'h0B) state_n = ADDR;
`endif
          else begin
            state_n = IGNORE;
            cmd_err_n = 1'b1;
          end
        end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        ADDR: if (bit_cnt == 5'd23) state_n = fast ? DUMMY : DATA;
        DUMMY: if (bit_cnt == 5'd7) state_n = DATA;
`else
        ADDR: if (bit_cnt == 5'd23) state_n = DATA;
`endif
        default: ;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_q <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
      cs_d <= 1'b1;
      sclk_d <= 1'b0;
      busy <= 1'b0;
      cmd_err <= 1'b0;
      shift_in <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      addr_ptr <= '0;
      shift_out <= '0;
      spi.spi_miso <= 1'b0;
      spi.spi_miso_oe <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast <= 1'b0;
`endif
    end else begin
      cs_q <= {cs_q[SYNC_STAGES-2:0], spi.spi_cs};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi};
      cs_d <= cs_s;
      sclk_d <= sclk_s;
      busy <= ~cs_s;
      cmd_err <= cmd_err_n;
      if (cs_s || cs_fall) begin
        bit_cnt <= '0;
        bit_idx <= '0;
        spi.spi_miso <= 1'b0;
        spi.spi_miso_oe <= 1'b0;
      end else begin
        // bit_cnt restarts on every state change so each phase counts its own rises
        if (rise) begin
          shift_in <= shift_nxt[SW-2:0];
          bit_cnt <= state_n != state ? 5'd0 : bit_cnt + 5'd1;
        end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        if (state == CMD && state_n == ADDR) fast <= shift_nxt[7:0] == 8'h0B;
`endif
        if (state == ADDR && state_n != ADDR) addr_ptr <= shift_nxt[AW-1:0];
        if (state == DATA && fall) begin
          bit_idx <= bit_idx + 3'd1;
          spi.spi_miso_oe <= 1'b1;
          if (bit_idx == 3'd0) begin
            shift_out <= mem[addr_ptr];
            spi.spi_miso <= mem[addr_ptr][7];
            addr_ptr <= addr_ptr + AW'(1);
          end else begin
            shift_out <= shift_out << 1;
            spi.spi_miso <= shift_out[6];
          end
        end
      end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed read, wrap, bad-opcode, abort and reset checks
module tb_spi_flash_responder;
  localparam int HP = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_en = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic busy, cmd_err;
  int errors = 0;
  int checks = 0;
  int err_cycles = 0;
  spi_flash_responder_if spi();
  spi_flash_responder #(.DEPTH(256), .AW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi(spi.slave), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (cmd_err) err_cycles++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic half();
    repeat (HP) @(negedge clk);
  endtask
  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask
  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx, output logic any, output logic all);
    any = 1'b0;
    all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi.spi_mosi = tx[i];
      half();
      rx[i] = spi.spi_miso;
      any |= spi.spi_miso_oe;
      all &= spi.spi_miso_oe;
      spi.spi_sclk = 1'b1;
      half();
      spi.spi_sclk = 1'b0;
    end
  endtask
  task automatic hdr(input logic [7:0] op, input logic [23:0] a, output logic any);
    logic [7:0] rx;
    logic x, y;
    any = 1'b0;
    spi.spi_cs = 1'b0;
    half();
    xbyte(op, rx, x, y);
    any |= x;
    for (int i = 2; i >= 0; i--) begin
      xbyte(a[i*8 +: 8], rx, x, y);
      any |= x;
    end
  endtask
  task automatic deselect();
    spi.spi_cs = 1'b1;
    half();
    half();
  endtask
  task automatic read1(input string tag, input logic [23:0] a, input logic [7:0] exp);
    logic [7:0] rx;
    logic any, all;
    hdr(8'h03, a, any);
    xbyte(8'h00, rx, any, all);
    check(tag, rx, exp);
    deselect();
  endtask
  initial begin
    logic [7:0] rx;
    logic any, all;
    int e0;
    spi.spi_cs = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", spi.spi_miso, 0);
    check("rst_oe", spi.spi_miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cmd_err, 0);
    rst = 1'b0;
    preload(8'h10, 8'hA5);
    preload(8'h11, 8'h3C);
    preload(8'hFF, 8'h11);
    preload(8'h00, 8'h22);
    preload(8'h12, 8'hFF);
    e0 = err_cycles;
    hdr(8'h03, 24'h000010, any);
    check("busy_sel", busy, 1);
    check("hdr_oe", any, 0);
    xbyte(8'h00, rx, any, all);
    check("rd_b0", rx, 8'hA5);
    check("rd_b0_oe", all, 1);
    xbyte(8'h00, rx, any, all);
    check("rd_b1", rx, 8'h3C);
    check("rd_b1_oe", all, 1);
    spi.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("desel_oe", spi.spi_miso_oe, 0);
    half();
    check("desel_busy", busy, 0);
    check("rd_no_err", err_cycles - e0, 0);
    hdr(8'h03, 24'h0000FF, any);
    xbyte(8'h00, rx, any, all);
    check("wrap_b0", rx, 8'h11);
    xbyte(8'h00, rx, any, all);
    check("wrap_b1", rx, 8'h22);
    deselect();
    e0 = err_cycles;
    spi.spi_cs = 1'b0;
    half();
    xbyte(8'h9F, rx, any, all);
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      logic a1, a2;
      xbyte(8'hFF, r, a1, a2);
      any |= a1 | (r != 8'h00);
    end
    check("bad_quiet", any, 0);
    deselect();
    check("bad_err_pulse", err_cycles - e0, 1);
    read1("after_bad", 24'h000010, 8'hA5);
    spi.spi_cs = 1'b0;
    half();
    xbyte(8'h03, rx, any, all);
    xbyte(8'h00, rx, any, all);
    xbyte(8'h00, rx, any, all);
    for (int i = 0; i < 4; i++) begin
      spi.spi_mosi = 1'b1;
      half();
      spi.spi_sclk = 1'b1;
      half();
      spi.spi_sclk = 1'b0;
    end
    deselect();
    read1("after_abort", 24'h000010, 8'hA5);
    hdr(8'h03, 24'h000011, any);
    xbyte(8'h00, rx, any, all);
    check("pre_rst_b", rx, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      half();
      spi.spi_sclk = 1'b1;
      half();
      spi.spi_sclk = 1'b0;
    end
    half();
    check("pre_rst_oe", spi.spi_miso_oe, 1);
    check("pre_rst_miso", spi.spi_miso, 1);
    rst = 1'b1;
    spi.spi_cs = 1'b1;
    #1;
    check("rst_mid_oe", spi.spi_miso_oe, 0);
    check("rst_mid_miso", spi.spi_miso, 0);
    check("rst_mid_busy", busy, 0);
    half();
    rst = 1'b0;
    half();
    read1("kept_10", 24'h000010, 8'hA5);
    read1("kept_ff", 24'h0000FF, 8'h11);
    e0 = err_cycles;
    hdr(8'h0B, 24'h000011, any);
    xbyte(8'h00, rx, any, all);
    check("fast_dummy_oe", any, 0);
    xbyte(8'h00, rx, any, all);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    check("fast_data", rx, 8'h3C);
    check("fast_no_err", err_cycles - e0, 0);
`else
    check("fast_data", {rx, any}, 9'h000);
    check("fast_err", err_cycles - e0, 1);
`endif
    deselect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
